dram_access_arbiter: RTL and testbench
======================================

Name: dram_access_arbiter

Overview:
- Shares the single SDRAM command sequencer between three requesters:
  - VGA scan-line fetch: read-only, deadline-critical.
  - CPU memory/cache traffic: read and write.
  - Internally timed auto-refresh.
- Sits between the requesters and the SDRAM command/timing sequencer inside core_main.
- Issues one operation at a time over a valid/ready command handshake, and waits for the sequencer's completion pulse before re-arbitrating.

Parameters:
- REFRESH_INTERVAL, 700, main_clk cycles between refresh ticks (7.8 us at 90 MHz).
- REFRESH_URGENT, 2, pending-refresh count at or above which refresh outranks VGA.
- VGA_MAX_STREAK, 4, maximum consecutive VGA grants while the CPU is waiting.

Ports:
- main_clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- vga_req  in  1  VGA read request; level, held until vga_done.
- vga_addr  in  25  VGA word address {bank, row, col}.
- vga_done  out  1  one-cycle pulse: VGA operation complete.
- cpu_req  in  1  CPU request; level, held until cpu_done.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  25  CPU word address.
- cpu_done  out  1  one-cycle pulse: CPU operation complete.
- cmd_valid  out  1  command presented to the sequencer.
- cmd_ready  in  1  sequencer accepts the command.
- cmd_refresh  out  1  command is auto-refresh; address is don't-care.
- cmd_write  out  1  command is a write.
- cmd_addr  out  25  command word address.
- op_done  in  1  one-cycle pulse: accepted command finished.
- refresh_pending  out  3  outstanding refresh count.
- refresh_overrun  out  1  sticky flag: pending count saturated.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0; state = IDLE; counters and streak cleared.
  - A reset mid-operation abandons the operation silently; no done pulse is issued.
- Refresh timer:
  - Counts 0..REFRESH_INTERVAL-1, then wraps to 0; the wrap cycle is a tick.
  - Each tick increments refresh_pending, saturating at 7.
  - A tick while pending is already 7 sets refresh_overrun; it clears only on reset.
  - A tick in the same cycle as a refresh op_done leaves pending unchanged (+1 -1).
- State machine: IDLE -> ISSUE -> BUSY -> IDLE.
- IDLE: each cycle, evaluate priority, first match wins:
  1. refresh_pending >= REFRESH_URGENT.
  2. vga_req, unless streak == VGA_MAX_STREAK and cpu_req.
  3. cpu_req.
  4. refresh_pending != 0 (opportunistic refresh).
  5. No match: stay in IDLE.
- On a win:
  - Register owner, cmd_refresh, cmd_write (VGA always 0) and cmd_addr.
  - Go to ISSUE; cmd_valid goes high the cycle after the winning evaluation (1-cycle latency).
- ISSUE:
  - Hold cmd_valid and all cmd_* fields stable until cmd_ready is sampled high.
  - On that edge, drop cmd_valid and go to BUSY.
- BUSY: wait for op_done. On the op_done cycle:
  - Register a done pulse to the owner: vga_done or cpu_done high for exactly the next cycle; refresh ops decrement pending instead.
  - Return to IDLE.
  - The earliest next cmd_valid is 2 cycles after op_done.
- Streak counter:
  - Increments on each VGA grant made while cpu_req is high.
  - Resets to 0 on any CPU grant, or on a VGA grant made with cpu_req low.
  - Saturates at VGA_MAX_STREAK.
- Request capture:
  - Requester inputs are sampled only in IDLE.
  - Dropping a req after the grant does not cancel the operation; the done pulse is still issued.
  - A req still high in the cycle after its done pulse is treated as a new request.
- Spurious inputs: op_done outside BUSY and cmd_ready outside ISSUE are ignored.

Test Plan:
- Only cpu_req=1, cpu_write=1, cpu_addr=0x0ABCDEF; cmd_ready tied 1; op_done 5 cycles after acceptance -> cmd_valid one cycle after the request, cmd_write=1, cmd_addr=0x0ABCDEF, single cpu_done pulse the cycle after op_done.
- vga_req and cpu_req both held high, pending=0, VGA_MAX_STREAK=4 -> grant order VGA, VGA, VGA, VGA, CPU, VGA, ...
- REFRESH_INTERVAL=16, both requesters idle -> refresh issued after the first tick (cmd_refresh=1); refresh_pending returns 1 -> 0 on op_done.
- REFRESH_INTERVAL=16, vga_req held high, op_done withheld for 40 cycles -> pending reaches 2; the next arbitration grants refresh ahead of VGA.
- cmd_ready held low for 200 cycles, REFRESH_INTERVAL=16 -> pending saturates at 7, refresh_overrun=1 and stays 1 after the later completions.
- Assert reset while in BUSY -> cmd_valid, vga_done, cpu_done and refresh_pending are 0 immediately; the subsequent op_done produces no done pulse.

Source files
------------

// File: rtl/dram_access_arbiter_if.sv
// Handshake and bus bundle between the requesters, the SDRAM sequencer and the access arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface dram_access_arbiter_if;
    logic        vga_req;
    logic [24:0] vga_addr;
    logic        vga_done;
    logic        cpu_req;
    logic        cpu_write;
    logic [24:0] cpu_addr;
    logic        cpu_done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_refresh;
    logic        cmd_write;
    logic [24:0] cmd_addr;
    logic        op_done;
    logic [2:0]  refresh_pending;
    logic        refresh_overrun;

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_write, cpu_addr, cmd_ready, op_done,
        output vga_done, cpu_done, cmd_valid, cmd_refresh, cmd_write, cmd_addr,
               refresh_pending, refresh_overrun
    );

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_write, cpu_addr, cmd_ready, op_done,
        input  vga_done, cpu_done, cmd_valid, cmd_refresh, cmd_write, cmd_addr,
               refresh_pending, refresh_overrun
    );
endinterface

// File: rtl/dram_access_arbiter.sv
// Arbitrates VGA fetch, CPU traffic and auto-refresh onto the single SDRAM command sequencer,
// one operation at a time, re-arbitrating only after the sequencer reports completion.
module dram_access_arbiter #(
    parameter int REFRESH_INTERVAL = 700,
    parameter int REFRESH_URGENT   = 2,
    parameter int VGA_MAX_STREAK   = 4
) (
    input logic                  main_clk,
    input logic                  reset,
    dram_access_arbiter_if.slave bus
);
    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int SW = $clog2(VGA_MAX_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU, OWN_REF} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        grant;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_refresh_q, cmd_refresh_d;
    logic          cmd_write_q, cmd_write_d;
    logic [24:0]   cmd_addr_q, cmd_addr_d;
    logic          vga_done_q, vga_done_d;
    logic          cpu_done_q, cpu_done_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          tick;
    logic          refDone;

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            cmd_valid_q   <= 1'b0;
            cmd_refresh_q <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            vga_done_q    <= 1'b0;
            cpu_done_q    <= 1'b0;
            timer_q       <= '0;
            pending_q     <= '0;
            overrun_q     <= 1'b0;
            streak_q      <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_refresh_q <= cmd_refresh_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            vga_done_q    <= vga_done_d;
            cpu_done_q    <= cpu_done_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            streak_q      <= streak_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        grant         = OWN_NONE;
        cmd_valid_d   = cmd_valid_q;
        cmd_refresh_d = cmd_refresh_q;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        vga_done_d    = 1'b0;
        cpu_done_d    = 1'b0;
        streak_d      = streak_q;
        refDone       = 1'b0;

        case (state_q)
            IDLE: begin
                // An urgent refresh backlog beats the VGA deadline; VGA yields after a full streak.
                if (pending_q >= 3'(REFRESH_URGENT)) begin
                    grant = OWN_REF;
                end else if (bus.vga_req &&
                             !(streak_q == SW'(VGA_MAX_STREAK) && bus.cpu_req)) begin
                    grant = OWN_VGA;
                end else if (bus.cpu_req) begin
                    grant = OWN_CPU;
                end else if (pending_q != 3'd0) begin
                    grant = OWN_REF;
                end

                if (grant == OWN_VGA) begin
                    if (!bus.cpu_req) begin
                        streak_d = '0;
                    end else if (streak_q != SW'(VGA_MAX_STREAK)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (grant == OWN_CPU) begin
                    streak_d = '0;
                end

                if (grant != OWN_NONE) begin
                    state_d       = ISSUE;
                    owner_d       = grant;
                    cmd_valid_d   = 1'b1;
                    cmd_refresh_d = (grant == OWN_REF);
                    cmd_write_d   = (grant == OWN_CPU) && bus.cpu_write;
                    cmd_addr_d    = (grant == OWN_VGA) ? bus.vga_addr :
                                    (grant == OWN_CPU) ? bus.cpu_addr : 25'd0;
                end
            end
            ISSUE: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus.op_done) begin
                    state_d    = IDLE;
                    vga_done_d = (owner_q == OWN_VGA);
                    cpu_done_d = (owner_q == OWN_CPU);
                    refDone    = (owner_q == OWN_REF);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh bookkeeping: a tick coinciding with a refresh completion cancels out.
    always_comb begin
        tick      = (timer_q == TW'(REFRESH_INTERVAL - 1));
        timer_d   = tick ? '0 : timer_q + TW'(1);
        pending_d = pending_q;
        overrun_d = overrun_q | (tick && pending_q == 3'd7);
        if (tick && !refDone) begin
            if (pending_q != 3'd7) begin
                pending_d = pending_q + 3'd1;
            end
        end else if (!tick && refDone && pending_q != 3'd0) begin
            pending_d = pending_q - 3'd1;
        end
    end

    assign bus.vga_done        = vga_done_q;
    assign bus.cpu_done        = cpu_done_q;
    assign bus.cmd_valid       = cmd_valid_q;
    assign bus.cmd_refresh     = cmd_refresh_q;
    assign bus.cmd_write       = cmd_write_q;
    assign bus.cmd_addr        = cmd_addr_q;
    assign bus.refresh_pending = pending_q;
    assign bus.refresh_overrun = overrun_q;
endmodule

// File: tb/tb_dram_access_arbiter.sv
// Randomized scoreboard bench for dram_access_arbiter: a transaction-level reference model
// predicts each command and done pulse, and a negedge monitor compares what the DUT presents.
module tb_dram_access_arbiter;
    localparam int RI  = 16;
    localparam int RU  = 2;
    localparam int VMS = 4;

    logic mainClk = 1'b0;
    logic rst     = 1'b1;

    dram_access_arbiter_if bus();

    dram_access_arbiter #(
        .REFRESH_INTERVAL(RI),
        .REFRESH_URGENT  (RU),
        .VGA_MAX_STREAK  (VMS)
    ) dut (
        .main_clk(mainClk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 mainClk = ~mainClk;

    typedef struct {
        logic        refresh;
        logic        write;
        logic [24:0] addr;
        int          cycle;
    } cmd_exp_t;

    typedef struct {
        int owner;
        int cycle;
    } done_exp_t;

    cmd_exp_t  cmdQ[$];
    done_exp_t doneQ[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state: phase 0 = free, 1 = command offered, 2 = command executing.
    int mPhase   = 0;
    int mOwner   = 0;
    int mPending = 0;
    int mTimer   = 0;
    int mStreak  = 0;
    bit mOverrun = 0;

    // Stimulus knobs (percent probabilities, op_done delay range).
    int vgaProb, cpuProb, keepProb, readyProb, dlyMin, dlyMax, spurProb;
    bit fixedCpu;
    int seqCnt = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // The model sees the same pre-edge inputs as the DUT and predicts grants from the priority rules.
    always @(posedge mainClk) begin
        int tickNow;
        int decNow;
        int winner;
        cmd_exp_t c;
        done_exp_t d;
        cyc++;
        if (rst) begin
            mPhase = 0; mOwner = 0; mPending = 0; mTimer = 0; mStreak = 0; mOverrun = 0;
            cmdQ.delete();
            doneQ.delete();
        end else begin
            tickNow = (mTimer == RI - 1) ? 1 : 0;
            mTimer  = (tickNow == 1) ? 0 : mTimer + 1;
            decNow  = 0;
            if (mPhase == 0) begin
                winner = 0;
                if (mPending >= RU) winner = 3;
                else if (bus.vga_req && !(mStreak == VMS && bus.cpu_req)) winner = 1;
                else if (bus.cpu_req) winner = 2;
                else if (mPending > 0) winner = 3;
                if (winner != 0) begin
                    c.refresh = (winner == 3);
                    c.write   = (winner == 2) ? bus.cpu_write : 1'b0;
                    c.addr    = (winner == 1) ? bus.vga_addr : (winner == 2) ? bus.cpu_addr : 25'd0;
                    c.cycle   = cyc;
                    cmdQ.push_back(c);
                    if (winner == 1) mStreak = bus.cpu_req ? ((mStreak < VMS) ? mStreak + 1 : VMS) : 0;
                    if (winner == 2) mStreak = 0;
                    mOwner = winner;
                    mPhase = 1;
                end
            end else if (mPhase == 1) begin
                if (bus.cmd_ready) mPhase = 2;
            end else if (bus.op_done) begin
                if (mOwner == 3) begin
                    decNow = 1;
                end else begin
                    d.owner = mOwner;
                    d.cycle = cyc;
                    doneQ.push_back(d);
                end
                mPhase = 0;
            end
            if (tickNow == 1 && mPending == 7) mOverrun = 1;
            mPending = mPending + tickNow - decNow;
            if (mPending > 7) mPending = 7;
        end
    end

    // Monitor: pops expectations whenever the DUT offers a command or pulses a done.
    logic     prevValid = 1'b0;
    bit       curOk     = 0;
    cmd_exp_t cur;

    always @(negedge mainClk) begin
        done_exp_t d;
        if (rst) begin
            prevValid = 1'b0;
            curOk     = 0;
        end else begin
            if (bus.cmd_valid && !prevValid) begin
                if (cmdQ.size() == 0) begin
                    failNow("unexpectedCmd", "cmd_valid rose with no predicted grant");
                    curOk = 0;
                end else begin
                    cur   = cmdQ.pop_front();
                    curOk = 1;
                    checkOutput("cmdStartCycle", cyc, cur.cycle);
                end
            end else if (!bus.cmd_valid && cmdQ.size() > 0 && cmdQ[0].cycle < cyc) begin
                failNow("missingCmd", "predicted command never offered");
                void'(cmdQ.pop_front());
            end
            if (bus.cmd_valid && curOk) begin
                checkOutput("cmdRefresh", bus.cmd_refresh, cur.refresh);
                checkOutput("cmdWrite", bus.cmd_write, cur.write);
                if (!cur.refresh) checkOutput("cmdAddr", bus.cmd_addr, cur.addr);
            end
            prevValid = bus.cmd_valid;

            if (bus.vga_done && bus.cpu_done) failNow("doubleDone", "vga_done and cpu_done together");
            if (bus.vga_done || bus.cpu_done) begin
                if (doneQ.size() == 0) begin
                    failNow("unexpectedDone", "done pulse with no completed operation");
                end else begin
                    d = doneQ.pop_front();
                    checkOutput("doneOwner", bus.vga_done ? 1 : 2, d.owner);
                    checkOutput("doneCycle", cyc, d.cycle);
                end
            end else if (doneQ.size() > 0 && doneQ[0].cycle < cyc) begin
                failNow("missingDone", "predicted done pulse absent");
                void'(doneQ.pop_front());
            end

            checkOutput("refreshPending", bus.refresh_pending, mPending);
            checkOutput("refreshOverrun", bus.refresh_overrun, mOverrun);
        end
    end

    // One cycle of sequencer and requester behaviour, applied just after the falling edge.
    task automatic applyStimulus();
        bus.op_done = 1'b0;
        if (seqCnt > 0) begin
            seqCnt--;
            if (seqCnt == 0) bus.op_done = 1'b1;
        end else if ($urandom_range(99) < spurProb) begin
            bus.op_done = 1'b1;
        end
        bus.cmd_ready = ($urandom_range(99) < readyProb);
        if (bus.cmd_valid && bus.cmd_ready && seqCnt == 0) seqCnt = $urandom_range(dlyMax, dlyMin);

        if (rst) begin
            bus.vga_req = 1'b0;
            bus.cpu_req = 1'b0;
        end else begin
            if (bus.vga_done) begin
                bus.vga_req  = ($urandom_range(99) < keepProb);
                bus.vga_addr = 25'($urandom);
            end else if (!bus.vga_req && $urandom_range(99) < vgaProb) begin
                bus.vga_req  = 1'b1;
                bus.vga_addr = 25'($urandom);
            end
            if (bus.cpu_done || (!bus.cpu_req && $urandom_range(99) < cpuProb)) begin
                bus.cpu_req   = bus.cpu_done ? ($urandom_range(99) < keepProb) : 1'b1;
                bus.cpu_write = fixedCpu ? 1'b1 : 1'($urandom_range(1));
                bus.cpu_addr  = fixedCpu ? 25'h0ABCDEF : 25'($urandom);
            end
        end
    endtask

    task automatic runPhase(input int cycles, input int vP, input int cP, input int kP, input int rP,
                            input int dMin, input int dMax, input int sP, input bit fx);
        vgaProb = vP; cpuProb = cP; keepProb = kP; readyProb = rP;
        dlyMin = dMin; dlyMax = dMax; spurProb = sP; fixedCpu = fx;
        repeat (cycles) begin
            @(negedge mainClk);
            applyStimulus();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "CmdValid"}, bus.cmd_valid, 0);
        checkOutput({tag, "VgaDone"}, bus.vga_done, 0);
        checkOutput({tag, "CpuDone"}, bus.cpu_done, 0);
        checkOutput({tag, "Pending"}, bus.refresh_pending, 0);
        checkOutput({tag, "Overrun"}, bus.refresh_overrun, 0);
    endtask

    initial begin
        int waited;
        bus.vga_req = 1'b0; bus.vga_addr = '0; bus.cpu_req = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_addr = '0; bus.cmd_ready = 1'b0; bus.op_done = 1'b0;
        vgaProb = 0; cpuProb = 0; keepProb = 0; readyProb = 0;
        dlyMin = 1; dlyMax = 1; spurProb = 0; fixedCpu = 0;

        repeat (3) @(negedge mainClk);
        checkResetOutputs("reset");
        rst = 1'b0;

        $display("[TB] CPU-only writes to 0x0ABCDEF");
        runPhase(60, 0, 30, 0, 100, 5, 5, 0, 1);
        $display("[TB] VGA and CPU held together");
        runPhase(150, 100, 100, 100, 100, 1, 6, 0, 0);
        $display("[TB] requesters idle, refresh only");
        runPhase(60, 0, 0, 0, 100, 2, 4, 0, 0);
        $display("[TB] VGA held with slow completions");
        runPhase(150, 100, 0, 100, 100, 40, 40, 0, 0);

        $display("[TB] sequencer stalled");
        runPhase(200, 50, 50, 100, 0, 2, 6, 0, 0);
        checkOutput("stallPendingSaturated", bus.refresh_pending, 7);
        checkOutput("stallOverrunSet", bus.refresh_overrun, 1);
        runPhase(150, 30, 30, 50, 100, 1, 6, 0, 0);
        checkOutput("overrunSticky", bus.refresh_overrun, 1);

        $display("[TB] randomized mix");
        runPhase(2500, 20, 20, 50, 70, 1, 8, 5, 0);

        $display("[TB] reset during an executing operation");
        vgaProb = 60; cpuProb = 60; keepProb = 50; readyProb = 100;
        dlyMin = 10; dlyMax = 10; spurProb = 0; fixedCpu = 0;
        waited = 0;
        do begin
            @(negedge mainClk);
            applyStimulus();
            waited++;
        end while (seqCnt != 9 && waited < 300);
        if (seqCnt != 9) failNow("busyWait", "no operation reached execution in time");
        #2 rst = 1'b1;
        #1 checkResetOutputs("midReset");
        vgaProb = 0; cpuProb = 0; keepProb = 0;
        repeat (2) begin
            @(negedge mainClk);
            applyStimulus();
        end
        rst = 1'b0;
        runPhase(14, 0, 0, 0, 100, 2, 4, 0, 0);
        checkOutput("postResetOverrun", bus.refresh_overrun, 0);

        runPhase(600, 25, 25, 50, 80, 1, 8, 3, 0);

        vgaProb = 0; cpuProb = 0; keepProb = 0; spurProb = 0; readyProb = 100;
        waited = 0;
        do begin
            @(negedge mainClk);
            applyStimulus();
            waited++;
        end while ((cmdQ.size() != 0 || doneQ.size() != 0 || seqCnt != 0 ||
                    bus.vga_req || bus.cpu_req) && waited < 500);
        repeat (3) begin
            @(negedge mainClk);
            applyStimulus();
        end
        checkOutput("drainCmdQueue", cmdQ.size(), 0);
        checkOutput("drainDoneQueue", doneQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
